mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Sits directly downstream of the multi-cycle DLX control FSM. Consumes its MemRead, MemWrite, IorD and IRWrite strobes and turns each one into a single request/acknowledge transaction on a word-wide memory bus.
- Latches fetched instructions into the instruction register (IR) and loaded words into the memory data register (MDR).
- Drives stall to freeze the control FSM until the bus acknowledges, and raises a sticky fault on misalignment, illegal strobes or bus timeout.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; bus_be is DATA_W/8 bits.
- TIMEOUT, 15, maximum cycles waiting for bus_ack before fault (1..2^CNT_W-1).
- CNT_W, 4, wait counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- mem_read  in  1  MemRead strobe from control.
- mem_write  in  1  MemWrite strobe from control.
- iord  in  1  0: address = pc; 1: address = alu_out.
- ir_write  in  1  capture read data into IR.
- pc  in  ADDR_W  program counter.
- alu_out  in  ADDR_W  ALU result register (load/store address).
- store_data  in  DATA_W  register B value for SW.
- bus_req  out  1  transaction request.
- bus_we  out  1  1 = write.
- bus_addr  out  ADDR_W  word address, bits [1:0] = 0.
- bus_wdata  out  DATA_W  write data.
- bus_be  out  DATA_W/8  byte enables, all ones.
- bus_ack  in  1  transaction complete; rdata valid in the same cycle.
- bus_rdata  in  DATA_W  read data.
- instr  out  DATA_W  instruction register.
- mdr  out  DATA_W  memory data register.
- stall  out  1  hold control FSM (clock enable = !stall).
- fault  out  1  sticky error.
- fault_code  out  2  00 none, 01 misaligned, 10 read+write, 11 timeout.

Behaviour:
- Reset values (asynchronous): state IDLE, counter 0, bus_req 0, bus_we 0, bus_addr 0, bus_wdata 0, instr 0, mdr 0, fault 0, fault_code 00.
  - bus_be is constant all ones.
  - Reset during WAIT drops bus_req immediately; the transaction is abandoned and nothing is captured.
- FSM has three states: IDLE, WAIT, FAULT.
- IDLE:
  - Request = mem_read | mem_write. The address is selected by iord.
  - mem_read & mem_write both high -> FAULT, code 10.
  - Otherwise, address[1:0] != 0 -> FAULT, code 01. No bus_req is issued in either fault case.
  - Otherwise, at the clock edge the block registers bus_req=1, bus_we=mem_write, bus_addr, bus_wdata=store_data, and records a read destination of IR if ir_write, else MDR. It then moves to WAIT with counter 0.
- WAIT:
  - bus_req, bus_we, bus_addr and bus_wdata are held stable.
  - On bus_ack: drop bus_req; if the transaction is a read, capture bus_rdata into instr or mdr at that edge; return to IDLE.
  - On no ack: counter increments. When counter == TIMEOUT-1 and no ack, go to FAULT with code 11 and drop bus_req.
  - Ack arriving on the same cycle as the timeout edge wins (normal completion).
- FAULT: absorbing until reset. bus_req stays 0, fault=1, stall=1.
- stall is combinational:
  - 1 in IDLE when a request is presented.
  - 1 in WAIT unless bus_ack.
  - 1 in FAULT.
  - 0 otherwise.
  - The control FSM therefore advances exactly on the ack edge, and IR/MDR are valid from the next cycle.
- Latency: request cycle N -> bus_req high N+1 -> ack at cycle N+1+k (k wait states) -> stall low in the ack cycle. Zero-wait access = 2 stalled-or-acked cycles.
- A write never modifies instr or mdr. A read with ir_write=0 leaves instr unchanged.
- bus_ack seen in IDLE or FAULT is ignored.
- Back-to-back: a new request presented in IDLE on the cycle right after completion is accepted normally. No bus_req-low gap is required beyond that one IDLE cycle.

Decomposition:
- Shared package (dlx_pkg) holds:
  - FSM state encoding (IDLE, WAIT, FAULT).
  - fault_code constants (FAULT_NONE, FAULT_ALIGN, FAULT_RW, FAULT_TIMEOUT).
  - Default DATA_W/ADDR_W.
- One natural sub-module, mem_wait_timer: the CNT_W counter with clear/enable and a timeout compare output. All remaining logic stays in mem_access_unit.

Test Plan:
- Fetch, zero wait: pc=0x100, iord=0, mem_read=1, ir_write=1; ack with rdata=0x8C220004 in the first bus_req cycle -> bus_addr=0x100, bus_we=0; instr=0x8C220004 next cycle; mdr unchanged; stall high for 1 cycle.
- Load, 3 wait states: alu_out=0x2000, iord=1, mem_read=1; ack on the 4th bus_req cycle with 0xDEADBEEF -> stall high for 4 cycles; mdr=0xDEADBEEF; instr unchanged.
- Store: alu_out=0x40, store_data=0x12345678, mem_write=1; ack after 1 wait -> bus_we=1, bus_wdata=0x12345678, bus_be=0xF; instr and mdr unchanged.
- Timeout: read with no ack, TIMEOUT=15 -> bus_req drops after 15 cycles; fault=1, fault_code=11, stall stuck at 1. A late ack is ignored. Reset clears everything to 0.
- Misaligned and illegal strobes:
  - alu_out=0x2002, iord=1, mem_read=1 -> no bus_req; fault_code=01.
  - After reset, mem_read=mem_write=1 -> no bus_req; fault_code=10.
- Reset mid-WAIT: assert reset during the 2nd wait cycle -> bus_req=0 immediately; instr and mdr = 0. The next fetch after reset completes normally.

Source files
------------

// File: rtl/dlx_pkg.sv
// Shared definitions for the DLX memory-side blocks: FSM encoding, fault codes
// and default bus widths.
package dlx_pkg;

  localparam int DLX_ADDR_W = 32;
  localparam int DLX_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ALIGN   = 2'b01;
  localparam logic [1:0] FAULT_RW      = 2'b10;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b11;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state counter for an outstanding bus transaction; flags the last
// cycle allowed before the transaction is declared timed out.
module mem_wait_timer #(
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign timeout = (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// Turns the DLX control strobes into single req/ack bus transactions, captures
// IR/MDR, stalls control while a transaction is outstanding, and latches faults.
module mem_access_unit
  import dlx_pkg::*;
#(
  parameter int ADDR_W  = DLX_ADDR_W,
  parameter int DATA_W  = DLX_DATA_W,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  iord,
  input  logic                  ir_write,
  input  logic [ADDR_W-1:0]     pc,
  input  logic [ADDR_W-1:0]     alu_out,
  input  logic [DATA_W-1:0]     store_data,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [DATA_W-1:0]     bus_wdata,
  output logic [DATA_W/8-1:0]   bus_be,
  input  logic                  bus_ack,
  input  logic [DATA_W-1:0]     bus_rdata,
  output logic [DATA_W-1:0]     instr,
  output logic [DATA_W-1:0]     mdr,
  output logic                  stall,
  output logic                  fault,
  output logic [1:0]            fault_code,
  output logic [1:0]            dbg_state
);

  // Bus handshake: bus_req rises on the edge after a request is accepted and
  // holds we/addr/wdata stable until the first cycle with bus_ack high; that
  // cycle completes the transfer (rdata valid in it) and bus_req drops on its
  // edge. Only one transaction is ever outstanding.

  state_e              state_q, state_d;
  logic                bus_req_q, bus_req_d;
  logic                bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic                dest_ir_q, dest_ir_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic [DATA_W-1:0]   mdr_q, mdr_d;
  logic [1:0]          fault_code_q, fault_code_d;

  logic                req;
  logic [ADDR_W-1:0]   sel_addr;
  logic                timer_clear;
  logic                timer_en;
  logic                timeout;

  assign req      = mem_read | mem_write;
  assign sel_addr = iord ? alu_out : pc;

  mem_wait_timer #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (timer_en),
    .timeout (timeout)
  );

  always_comb begin
    state_d      = state_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    dest_ir_d    = dest_ir_q;
    instr_d      = instr_q;
    mdr_d        = mdr_q;
    fault_code_d = fault_code_q;
    timer_clear  = 1'b0;
    timer_en     = 1'b0;
    stall        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          stall = 1'b1;
          if (mem_read && mem_write) begin
            state_d      = ST_FAULT;
            fault_code_d = FAULT_RW;
          end else if (sel_addr[1:0] != 2'b00) begin
            state_d      = ST_FAULT;
            fault_code_d = FAULT_ALIGN;
          end else begin
            state_d     = ST_WAIT;
            bus_req_d   = 1'b1;
            bus_we_d    = mem_write;
            bus_addr_d  = sel_addr;
            bus_wdata_d = store_data;
            dest_ir_d   = ir_write;
            timer_clear = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        // An ack on the timeout cycle still completes the transfer normally.
        if (bus_ack) begin
          state_d   = ST_IDLE;
          bus_req_d = 1'b0;
          if (!bus_we_q) begin
            if (dest_ir_q) begin
              instr_d = bus_rdata;
            end else begin
              mdr_d = bus_rdata;
            end
          end
        end else begin
          stall = 1'b1;
          if (timeout) begin
            state_d      = ST_FAULT;
            fault_code_d = FAULT_TIMEOUT;
            bus_req_d    = 1'b0;
          end else begin
            timer_en = 1'b1;
          end
        end
      end
      ST_FAULT: begin
        stall = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      dest_ir_q    <= 1'b0;
      instr_q      <= '0;
      mdr_q        <= '0;
      fault_code_q <= FAULT_NONE;
    end else begin
      state_q      <= state_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      dest_ir_q    <= dest_ir_d;
      instr_q      <= instr_d;
      mdr_q        <= mdr_d;
      fault_code_q <= fault_code_d;
    end
  end

  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign bus_be     = '1;
  assign instr      = instr_q;
  assign mdr        = mdr_q;
  assign fault      = (state_q == ST_FAULT);
  assign fault_code = fault_code_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: drivers push expected bus requests and
// IR/MDR contents; independent monitors pop and compare as the DUT presents them.
module tb_mem_access_unit;
  import dlx_pkg::*;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 4;
  localparam int BUS_W   = 1 + ADDR_W + DATA_W;

  logic                clk;
  logic                reset;
  logic                mem_read;
  logic                mem_write;
  logic                iord;
  logic                ir_write;
  logic [ADDR_W-1:0]   pc;
  logic [ADDR_W-1:0]   alu_out;
  logic [DATA_W-1:0]   store_data;
  logic                bus_req;
  logic                bus_we;
  logic [ADDR_W-1:0]   bus_addr;
  logic [DATA_W-1:0]   bus_wdata;
  logic [DATA_W/8-1:0] bus_be;
  logic                bus_ack;
  logic [DATA_W-1:0]   bus_rdata;
  logic [DATA_W-1:0]   instr;
  logic [DATA_W-1:0]   mdr;
  logic                stall;
  logic                fault;
  logic [1:0]          fault_code;
  logic [1:0]          dbg_state;

  int checks = 0;
  int errors = 0;

  logic [BUS_W-1:0]    exp_q[$];
  logic [2*DATA_W-1:0] exp_reg_q[$];
  logic [DATA_W-1:0]   model_instr = '0;
  logic [DATA_W-1:0]   model_mdr = '0;

  mem_access_unit #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc         (pc),
    .alu_out    (alu_out),
    .store_data (store_data),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_be     (bus_be),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata),
    .instr      (instr),
    .mdr        (mdr),
    .stall      (stall),
    .fault      (fault),
    .fault_code (fault_code),
    .dbg_state  (dbg_state)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // bus request monitor: compares each new transaction against exp_q
  logic             req_seen = 1'b0;
  logic [BUS_W-1:0] bus_exp;
  always @(negedge clk) begin
    if (reset) begin
      req_seen = 1'b0;
    end else if (bus_req && !req_seen) begin
      req_seen = 1'b1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL bus_unexpected: bus_req at addr 0x%0h, required no request", bus_addr);
      end else begin
        bus_exp = exp_q.pop_front();
        check("bus_we",    64'(bus_we),    64'(bus_exp[BUS_W-1]));
        check("bus_addr",  64'(bus_addr),  64'(bus_exp[ADDR_W+DATA_W-1:DATA_W]));
        check("bus_wdata", 64'(bus_wdata), 64'(bus_exp[DATA_W-1:0]));
        check("bus_be",    64'(bus_be),    64'hF);
      end
    end else if (!bus_req) begin
      req_seen = 1'b0;
    end
  end

  // register monitor: one cycle after each acked transfer, IR/MDR must match
  logic                done_pending = 1'b0;
  logic [2*DATA_W-1:0] reg_exp;
  always @(negedge clk) begin
    if (done_pending && !reset) begin
      if (exp_reg_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL reg_unexpected: completion with instr 0x%0h mdr 0x%0h, none required", instr, mdr);
      end else begin
        reg_exp = exp_reg_q.pop_front();
        check("instr", 64'(instr), 64'(reg_exp[2*DATA_W-1:DATA_W]));
        check("mdr",   64'(mdr),   64'(reg_exp[DATA_W-1:0]));
      end
    end
    done_pending = bus_req && bus_ack && !reset;
  end

  // drivers
  task automatic idle_inputs();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    iord      = 1'b0;
    ir_write  = 1'b0;
    bus_ack   = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1 reset = 1'b0;
    model_instr = '0;
    model_mdr   = '0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_bus_req"},    64'(bus_req),    64'h0);
    check({tag, "_bus_we"},     64'(bus_we),     64'h0);
    check({tag, "_bus_addr"},   64'(bus_addr),   64'h0);
    check({tag, "_bus_wdata"},  64'(bus_wdata),  64'h0);
    check({tag, "_bus_be"},     64'(bus_be),     64'hF);
    check({tag, "_instr"},      64'(instr),      64'h0);
    check({tag, "_mdr"},        64'(mdr),        64'h0);
    check({tag, "_fault"},      64'(fault),      64'h0);
    check({tag, "_fault_code"}, 64'(fault_code), 64'h0);
    check({tag, "_stall"},      64'(stall),      64'h0);
    check({tag, "_state"},      64'(dbg_state),  64'(ST_IDLE));
  endtask

  // One access; called at posedge+1. Ack is returned after `waits` wait states.
  task automatic access(input string name, input logic rd, input logic wr, input logic sel,
                        input logic irw, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] sd, input int waits,
                        input logic [DATA_W-1:0] rdata);
    int stall_cnt;
    mem_read   = rd;
    mem_write  = wr;
    iord       = sel;
    ir_write   = irw;
    store_data = sd;
    if (sel) alu_out = a;
    else     pc = a;
    exp_q.push_back({wr, a, sd});
    if (rd) begin
      if (irw) model_instr = rdata;
      else     model_mdr = rdata;
    end
    exp_reg_q.push_back({model_instr, model_mdr});
    stall_cnt = 0;
    @(negedge clk);
    if (stall) stall_cnt++;
    @(posedge clk);
    #1;
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      if (stall) stall_cnt++;
      @(posedge clk);
      #1;
    end
    bus_ack   = 1'b1;
    bus_rdata = rdata;
    @(negedge clk);
    if (stall) stall_cnt++;
    @(posedge clk);
    #1;
    idle_inputs();
    check({name, "_stall_cycles"}, 64'(stall_cnt), 64'(waits + 1));
  endtask

  // Presents an illegal request and checks that it faults without a bus request.
  task automatic illegal_request(input string name, input logic rd, input logic wr,
                                 input logic sel, input logic [ADDR_W-1:0] a,
                                 input logic [1:0] code);
    mem_read  = rd;
    mem_write = wr;
    iord      = sel;
    if (sel) alu_out = a;
    else     pc = a;
    @(negedge clk);
    check({name, "_req_stall"}, 64'(stall), 64'h1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check({name, "_bus_req"},    64'(bus_req),    64'h0);
    check({name, "_fault"},      64'(fault),      64'h1);
    check({name, "_fault_code"}, 64'(fault_code), 64'(code));
    check({name, "_stall"},      64'(stall),      64'h1);
  endtask

  initial begin
    int req_cycles;
    reset      = 1'b1;
    idle_inputs();
    pc         = '0;
    alu_out    = '0;
    store_data = '0;
    bus_rdata  = '0;
    @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk);
    #1 reset = 1'b0;

    // fetch, zero wait; load, 3 waits; store, 1 wait
    access("fetch", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'h0, 0, 32'h8C22_0004);
    access("load",  1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_2000, 32'h0, 3, 32'hDEAD_BEEF);
    access("store", 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h1234_5678, 1, 32'hFFFF_FFFF);

    // reset during the 2nd wait cycle abandons the transfer
    mem_read   = 1'b1;
    ir_write   = 1'b1;
    iord       = 1'b0;
    pc         = 32'h0000_0200;
    store_data = 32'h0;
    exp_q.push_back({1'b0, 32'h0000_0200, 32'h0});
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle_inputs();
    #1;
    check("midwait_bus_req", 64'(bus_req), 64'h0);
    check("midwait_instr",   64'(instr),   64'h0);
    check("midwait_mdr",     64'(mdr),     64'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    model_instr = '0;
    model_mdr   = '0;

    // fetch after reset, then back-to-back loads with no gap between calls
    access("refetch", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0, 0, 32'h2001_0005);
    access("b2b_a",   1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_1004, 32'h0, 0, 32'h0000_00A5);
    access("b2b_b",   1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_1008, 32'h0, 2, 32'h5A5A_0001);
    access("b2b_c",   1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_100C, 32'hCAFE_F00D, 0, 32'h0);

    // misaligned and illegal strobes
    do_reset();
    illegal_request("misaligned", 1'b1, 1'b0, 1'b1, 32'h0000_2002, FAULT_ALIGN);
    do_reset();
    illegal_request("read_write", 1'b1, 1'b1, 1'b0, 32'h0000_0100, FAULT_RW);
    do_reset();

    // timeout: read with no ack
    mem_read = 1'b1;
    iord     = 1'b1;
    alu_out  = 32'h0000_3000;
    store_data = 32'h0;
    exp_q.push_back({1'b0, 32'h0000_3000, 32'h0});
    @(posedge clk);
    #1;
    req_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus_req) break;
      req_cycles++;
    end
    check("timeout_req_cycles", 64'(req_cycles), 64'(TIMEOUT));
    check("timeout_fault",      64'(fault),      64'h1);
    check("timeout_fault_code", 64'(fault_code), 64'(FAULT_TIMEOUT));
    check("timeout_stall",      64'(stall),      64'h1);
    @(posedge clk);
    #1;
    bus_ack   = 1'b1;
    bus_rdata = 32'h7777_7777;
    @(negedge clk);
    check("late_ack_bus_req", 64'(bus_req), 64'h0);
    @(posedge clk);
    #1 bus_ack = 1'b0;
    @(negedge clk);
    check("late_ack_mdr",   64'(mdr),       64'h0);
    check("late_ack_fault", 64'(fault),     64'h1);
    check("late_ack_state", 64'(dbg_state), 64'(ST_FAULT));
    do_reset();
    @(negedge clk);
    check_reset_values("post_timeout_reset");

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0 || exp_reg_q.size() != 0) begin
      errors++;
      $display("FAIL queues_drained: %0d bus and %0d reg entries left, required 0",
               exp_q.size(), exp_reg_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
